multibyte_add_sequencer: RTL and testbench

//  Sequences one shared 8-bit ripple adder slice over NBYTES clock cycles, LSB byte first,
//  to add or subtract two 8*NBYTES-bit operands. A registered carry links the bytes.

---
 rtl/multibyte_add_sequencer_pkg.sv | 14 +
 rtl/multibyte_add_sequencer_adder8_carry.sv | 44 ++++
 rtl/multibyte_add_sequencer.sv | 133 +++++++++++++
 tb/tb_multibyte_add_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multibyte_add_sequencer_pkg.sv
// Shared definitions for the byte-serial add/subtract sequencer:
// FSM state encoding and the adder slice width.
package multibyte_add_sequencer_pkg;

   localparam int BYTE_W = 8;

   // Encoding 2'd3 is unused and recovers to ST_IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/multibyte_add_sequencer_adder8_carry.sv
// 8-bit combinational ripple-carry adder built from full_adder cells,
// with an explicit carry-in and carry-out so bytes can be chained over time.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

module adder8_carry
   import multibyte_add_sequencer_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              cin,
   output logic [BYTE_W-1:0] sum,
   output logic              cout
);

   logic [BYTE_W:0] carry_chain;

   assign carry_chain[0] = cin;

   generate
      for (genvar gi = 0; gi < BYTE_W; gi++) begin : g_fa
         full_adder u_fa (
            .a  (a[gi]),
            .b  (b[gi]),
            .ci (carry_chain[gi]),
            .s  (sum[gi]),
            .co (carry_chain[gi+1])
         );
      end
   endgenerate

   assign cout = carry_chain[BYTE_W];

endmodule

// File: rtl/multibyte_add_sequencer.sv
// Byte-serial add/subtract of two 8*NBYTES-bit operands through one shared
// 8-bit adder slice, LSB byte first, with valid/ready handshakes on both sides.
module multibyte_add_sequencer
   import multibyte_add_sequencer_pkg::*;
#(
   parameter int NBYTES = 4,
   parameter int IDXW   = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NBYTES*BYTE_W-1:0] a,
   input  logic [NBYTES*BYTE_W-1:0] b,
   input  logic                     op_sub,
   input  logic                     cin,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NBYTES*BYTE_W-1:0] sum,
   output logic                     cout,
   output logic                     ovf,
   output logic                     busy
);

   localparam int W = NBYTES * BYTE_W;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [W-1:0]      a_q, a_d;
   logic [W-1:0]      b_q, b_d;
   logic [W-1:0]      sum_q, sum_d;
   logic              carry_q, carry_d;
   logic              cout_q, cout_d;
   logic              ovf_q, ovf_d;

   logic [BYTE_W-1:0] a_byte, b_byte, slice_sum;
   logic              slice_cout;
   logic              last_byte;

   assign last_byte = (idx_q == IDXW'(NBYTES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid)  state_d = ST_RUN;
         ST_RUN:  if (last_byte) state_d = ST_DONE;
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
      busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
   end

   // Select the operand bytes for the current index into the shared slice.
   always_comb begin
      a_byte = '0;
      b_byte = '0;
      for (int i = 0; i < NBYTES; i++) begin
         if (idx_q == IDXW'(i)) begin
            a_byte = a_q[i*BYTE_W +: BYTE_W];
            b_byte = b_q[i*BYTE_W +: BYTE_W];
         end
      end
   end

   adder8_carry u_adder (
      .a    (a_byte),
      .b    (b_byte),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   always_comb begin
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      if (state_q == ST_IDLE && in_valid) begin
         // Subtraction is A + ~B + 1; cin is ignored in that case.
         a_d     = a;
         b_d     = b ^ {W{op_sub}};
         carry_d = op_sub | cin;
         idx_d   = '0;
      end else if (state_q == ST_RUN) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IDXW'(i)) begin
               sum_d[i*BYTE_W +: BYTE_W] = slice_sum;
            end
         end
         carry_d = slice_cout;
         idx_d   = idx_q + IDXW'(1);
         if (last_byte) begin
            cout_d = slice_cout;
            ovf_d  = (a_q[W-1] == b_q[W-1]) & (slice_sum[BYTE_W-1] != a_q[W-1]);
         end
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Scoreboard bench for multibyte_add_sequencer: the driver queues expected
// results as it issues requests, a negedge monitor pops them on each handshake.
module tb_multibyte_add_sequencer;

   localparam int NBYTES = 4;
   localparam int W      = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         op_sub = 1'b0;
   logic         cin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         busy;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   multibyte_add_sequencer #(.NBYTES(NBYTES), .IDXW(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op_sub    (op_sub),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [W-1:0] es, input logic ec, input logic eo);
      exp_t e;
      e.sum  = es;
      e.cout = ec;
      e.ovf  = eo;
      exp_q.push_back(e);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
   endtask

   // One request with out_ready high; checks latency from drive edge to out_valid.
   task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic s, input logic c,
                        input logic [W-1:0] es, input logic ec, input logic eo);
      int start;
      a        = ta;
      b        = tb_v;
      op_sub   = s;
      cin      = c;
      in_valid = 1'b1;
      push_exp(es, ec, eo);
      start = cyc;
      tick();
      in_valid = 1'b0;
      wait_valid();
      check({name, "_latency"}, 64'(cyc - start), 64'(NBYTES + 1));
      tick();
   endtask

   // Monitor: pops and compares on every result handshake.
   always @(negedge clk) begin
      if (!rst && out_valid) check("no_accept_in_done", {63'd0, in_ready}, 64'd0);
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual sum=%h required none", sum);
         end else begin
            mon_e = exp_q.pop_front();
            $display("txn t=%0d sum=%h cout=%0d ovf=%0d exp_sum=%h exp_cout=%0d exp_ovf=%0d",
                     cyc, sum, cout, ovf, mon_e.sum, mon_e.cout, mon_e.ovf);
            check("result_sum",  {32'd0, sum},  {32'd0, mon_e.sum});
            check("result_cout", {63'd0, cout}, {63'd0, mon_e.cout});
            check("result_ovf",  {63'd0, ovf},  {63'd0, mon_e.ovf});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acc0, acc1, acc2;
      int n;

      // Reset state
      tick();
      tick();
      check("rst_in_ready",  {63'd0, in_ready},  64'd1);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_busy",      {63'd0, busy},      64'd0);
      check("rst_sum",       {32'd0, sum},       64'd0);
      check("rst_cout",      {63'd0, cout},      64'd0);
      check("rst_ovf",       {63'd0, ovf},       64'd0);
      rst = 1'b0;
      tick();

      // Plain adds, carry-in, ripple across bytes
      do_op("add_small",  32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
      do_op("add_cin",    32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1, 32'h0000_0031, 1'b0, 1'b0);
      do_op("ripple",     32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
      do_op("wrap_cout",  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
      // Subtract (cin ignored) and signed overflow
      do_op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      do_op("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

      // Backpressure with a second request waiting
      out_ready = 1'b0;
      a = 32'h1234_5678; b = 32'h1111_1111; op_sub = 1'b0; cin = 1'b0;
      in_valid = 1'b1;
      push_exp(32'h2345_6789, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      wait_valid();
      a = 32'h0000_0010; b = 32'h0000_0020; op_sub = 1'b0; cin = 1'b0;
      in_valid = 1'b1;
      push_exp(32'h0000_0030, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_sum",       {32'd0, sum},       {32'd0, 32'h2345_6789});
         check("bp_out_valid", {63'd0, out_valid}, 64'd1);
         check("bp_in_ready",  {63'd0, in_ready},  64'd0);
      end
      out_ready = 1'b1;
      tick();
      check("bp_release_in_ready",  {63'd0, in_ready},  64'd1);
      check("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
      tick();
      check("bp_accept_busy",     {63'd0, busy},     64'd1);
      check("bp_accept_in_ready", {63'd0, in_ready}, 64'd0);
      in_valid = 1'b0;
      wait_valid();
      tick();

      // Reset in the second RUN cycle
      a = 32'h0000_0101; b = 32'h0000_0101; op_sub = 1'b0; cin = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      check("midrst_in_ready",  {63'd0, in_ready},  64'd1);
      check("midrst_busy",      {63'd0, busy},      64'd0);
      check("midrst_sum",       {32'd0, sum},       64'd0);
      check("midrst_cout",      {63'd0, cout},      64'd0);
      check("midrst_ovf",       {63'd0, ovf},       64'd0);
      rst = 1'b0;
      do_op("after_rst", 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0);

      // Back-to-back with in_valid and out_ready held high
      out_ready = 1'b1;
      a = 32'hFFFF_0000; b = 32'h0001_0000; op_sub = 1'b0; cin = 1'b0;
      push_exp(32'h0000_0000, 1'b1, 1'b0);
      in_valid = 1'b1;
      wait_ready();
      tick();
      acc0 = cyc;
      a = 32'h0000_0000; b = 32'h0000_0001; op_sub = 1'b1; cin = 1'b0;
      push_exp(32'hFFFF_FFFF, 1'b0, 1'b0);
      wait_ready();
      tick();
      acc1 = cyc;
      a = 32'h8000_0000; b = 32'h0000_0001; op_sub = 1'b1; cin = 1'b0;
      push_exp(32'h7FFF_FFFF, 1'b1, 1'b1);
      wait_ready();
      tick();
      acc2 = cyc;
      in_valid = 1'b0;
      check("b2b_period_1", 64'(acc1 - acc0), 64'(NBYTES + 2));
      check("b2b_period_2", 64'(acc2 - acc1), 64'(NBYTES + 2));

      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
